// File: rtl/fetch_pkg.sv
// Shared fetch-path types.
//   addr_t / bool_t / clock_t : basic scalar typedefs
//   fetch_entry_t             : {pc, instr, misaligned} payload held in fetch buffers
//   inflight_t                : one memory-latency pipe stage {valid, pc, misaligned}
//   NOP_INSTR                 : word substituted for misaligned fetches
package fetch_pkg;

  typedef logic [31:0] addr_t;
  typedef logic        bool_t;
  typedef logic        clock_t;

  localparam int unsigned INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    addr_t              pc;
    logic [INSTR_W-1:0] instr;
    bool_t              misaligned;
  } fetch_entry_t;

  typedef struct packed {
    bool_t valid;
    addr_t pc;
    bool_t misaligned;
  } inflight_t;

  // Instruction fetches must be word aligned.
  function automatic bool_t is_misaligned(input addr_t addr);
    return bool_t'(addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO of fetch_entry_t.
//   clk, rst_n  : clock, async active-low reset
//   clear       : synchronous empty (drops contents, pointers to 0)
//   push/push_data : write tail
//   pop         : consume head (ignored when empty)
//   head        : current head entry, valid while !empty
//   full/empty/count : occupancy status
// Simultaneous push and pop is legal at any occupancy, including full.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // At full a same-cycle pop frees the slot being written.
  assign do_push = push & (~full | do_pop);

  // Storage; reset to zero so the head reads 0 before first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and count; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(do_pop);
      count_q  <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(push && full && !pop))
    else $error("sync_fifo: push while full");

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer between the PC stage and decode.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_addr/req_ready : fetch address handshake from the PC stage
//   flush               : taken jump, kills in-flight and buffered fetches
//   mem_req/mem_addr    : read strobe/address to fixed-latency instruction memory
//   mem_rdata           : instruction word, MEM_LATENCY cycles after mem_req
//   instr_valid/instr/instr_pc/instr_misaligned : show-ahead head to decode
//   decode_ready        : decode consumes the head this cycle
module instr_fetch_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_misaligned,
  input  logic        decode_ready
);

  import fetch_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  inflight_t        pipe_q [MEM_LATENCY];
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  fetch_entry_t     hold_q;
  fetch_entry_t     out_entry;
  logic             req_mis;
  logic             accept;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight_count;
  logic [CNT_W-1:0] occupancy;

  // Credit check: a pop this cycle does not return its credit until next cycle.
  assign req_mis   = is_misaligned(req_addr);
  assign req_ready = rst_n & ~flush & (occupancy < CNT_W'(DEPTH));
  assign accept    = req_valid & req_ready;
  assign mem_req   = accept & ~req_mis;
  assign mem_addr  = req_addr;

  // In-flight occupancy; bounded by DEPTH through the credit check.
  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < int'(MEM_LATENCY); i++) begin
      inflight_count = inflight_count + CNT_W'(pipe_q[i].valid);
    end
  end

  assign occupancy = inflight_count + fifo_count;

  // Memory-latency shadow pipe; flush and reset kill everything in it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) pipe_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: accept, pc: req_addr, misaligned: req_mis};
      for (int i = 1; i < int'(MEM_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Last pipe stage lines up with mem_rdata for its request.
  always_comb begin
    push_entry            = '0;
    push_entry.pc         = pipe_q[MEM_LATENCY-1].pc;
    push_entry.misaligned = pipe_q[MEM_LATENCY-1].misaligned;
    push_entry.instr      = pipe_q[MEM_LATENCY-1].misaligned ? NOP_INSTR : mem_rdata;
  end

  assign fifo_push = pipe_q[MEM_LATENCY-1].valid & ~flush;
  assign fifo_pop  = ~fifo_empty & decode_ready & ~flush;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Keeps the last presented head so outputs hold steady while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (!fifo_empty) begin
      hold_q <= head;
    end
  end

  assign out_entry        = fifo_empty ? hold_q : head;
  assign instr_valid      = ~fifo_empty;
  assign instr            = out_entry.instr;
  assign instr_pc         = out_entry.pc;
  assign instr_misaligned = out_entry.misaligned;

  // Full status is covered by the FIFO's own overflow assertion.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned MEM_LATENCY = 1;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_misaligned;
  logic        decode_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_total = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        mis;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic        mq_v[$];
  logic [31:0] mq_a[$];

  instr_fetch_buffer #(
    .DEPTH       (DEPTH),
    .MEM_LATENCY (MEM_LATENCY),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_ready        (req_ready),
    .flush            (flush),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_misaligned (instr_misaligned),
    .decode_ready     (decode_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Fixed-latency memory: answers each strobe MEM_LATENCY cycles later, garbage otherwise.
  always begin : mem_model
    logic        v;
    logic [31:0] a;
    @(negedge clk);
    mq_v.push_back(mem_req);
    mq_a.push_back(mem_addr);
    @(posedge clk);
    #1;
    if (mq_v.size() >= MEM_LATENCY) begin
      v = mq_v.pop_front();
      a = mq_a.pop_front();
      mem_rdata = v ? mem_word(a) : $urandom;
    end else begin
      mem_rdata = $urandom;
    end
  end

  // Scoreboard: the queue holds every accepted fetch not yet consumed, in order.
  always @(negedge clk) begin : monitor
    logic exp_ready;
    logic exp_mreq;
    logic exp_valid;
    logic is_mis;
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      exp_ready = !flush && (sb_q.size() < DEPTH);
      check1("req_ready", req_ready, exp_ready);
      is_mis   = (req_addr % 4) != 0;
      exp_mreq = req_valid && exp_ready && !is_mis;
      check1("mem_req", mem_req, exp_mreq);
      if (exp_mreq) check32("mem_addr", mem_addr, req_addr);

      exp_valid = (sb_q.size() > 0) && (sb_q[0].due <= cyc);
      check1("instr_valid", instr_valid, exp_valid);
      if (instr_valid && exp_valid) begin
        check32("instr_pc", instr_pc, sb_q[0].pc);
        check32("instr", instr, sb_q[0].word);
        check1("instr_misaligned", instr_misaligned, sb_q[0].mis);
        if (decode_ready) void'(sb_q.pop_front());
      end

      if (req_valid && exp_ready) begin
        e.pc   = req_addr;
        e.mis  = is_mis;
        e.word = is_mis ? NOP : mem_word(req_addr);
        e.due  = cyc + MEM_LATENCY + 1;
        sb_q.push_back(e);
        acc_total++;
      end

      if (flush) sb_q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    int a0;
    logic [31:0] ra;
    rst_n        = 1'b0;
    req_valid    = 1'b1;
    req_addr     = 32'h100;
    flush        = 1'b0;
    decode_ready = 1'b0;
    mem_rdata    = '0;

    // Reset values, with a request pending so the reset gating is exercised.
    repeat (3) step();
    check1("rst_req_ready", req_ready, 1'b0);
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check32("rst_instr", instr, 32'h0);
    check32("rst_instr_pc", instr_pc, 32'h0);
    check1("rst_instr_mis", instr_misaligned, 1'b0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    step();

    // Short aligned stream.
    decode_ready = 1'b1;
    issue(32'h0);
    issue(32'h4);
    issue(32'h8);
    req_valid = 1'b0;
    repeat (4) step();

    // Back-pressure: only DEPTH credits available.
    decode_ready = 1'b0;
    a0 = acc_total;
    for (int i = 0; i < 8; i++) issue(32'h200 + 32'(4 * i));
    req_valid = 1'b0;
    check32("credit_accepts", 32'(acc_total - a0), 32'(DEPTH));
    check1("credit_full_ready", req_ready, 1'b0);
    decode_ready = 1'b1;
    step();
    check1("credit_return_ready", req_ready, 1'b1);
    repeat (6) step();

    // Flush while the second fetch's data returns.
    decode_ready = 1'b0;
    issue(32'h10);
    issue(32'h14);
    req_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    issue(32'h40);
    req_valid    = 1'b0;
    decode_ready = 1'b1;
    repeat (4) step();

    // Misaligned fetch yields a tagged NOP without a memory strobe.
    issue(32'h22);
    req_valid = 1'b0;
    repeat (4) step();

    // Reset mid-operation: 3 buffered, 1 in flight.
    decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'h300 + 32'(4 * i));
    req_valid = 1'b1;
    req_addr  = 32'h400;
    rst_n     = 1'b0;
    #1;
    check1("midrst_instr_valid", instr_valid, 1'b0);
    check1("midrst_req_ready", req_ready, 1'b0);
    check1("midrst_mem_req", mem_req, 1'b0);
    req_valid = 1'b0;
    step();
    rst_n        = 1'b1;
    decode_ready = 1'b1;
    repeat (5) step();

    // Random traffic with wrap-around, back-pressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) ra = ra | 32'($urandom_range(1, 3));
      req_valid    = ($urandom_range(0, 3) != 0);
      req_addr     = ra;
      decode_ready = (i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 39) == 0);
      step();
    end

    // Drain and confirm nothing was lost.
    req_valid    = 1'b0;
    flush        = 1'b0;
    decode_ready = 1'b1;
    repeat (10) step();
    check32("drain_left", 32'(sb_q.size()), 32'h0);
    check1("drain_instr_valid", instr_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
